// File: rtl/tawas_dbus_arb.sv
// Tawas data-bus arbiter: core has fixed priority, aux gets idle cycles plus a forced stall on starvation.
// Optional statistics counters are built when TAWAS_DBUS_ARB_STATS_EN is defined.
module tawas_dbus_arb #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef TAWAS_DBUS_ARB_STATS_EN
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_aux_gnt,
    output logic [CNT_W-1:0] stat_aux_wait,
    output logic [CNT_W-1:0] stat_stall,
`endif
    input  logic             c_cs,
    input  logic             c_wr,
    input  logic [31:0]      c_addr,
    input  logic [3:0]       c_mask,
    input  logic [31:0]      c_wdata,
    output logic [31:0]      c_rdata,
    output logic             core_stall,
    output logic             stall_viol,
    input  logic             a_req,
    input  logic             a_wr,
    input  logic [31:0]      a_addr,
    input  logic [3:0]       a_mask,
    input  logic [31:0]      a_wdata,
    output logic             a_gnt,
    output logic             a_rvld,
    output logic [31:0]      a_rdata,
    output logic             dcs,
    output logic             dwr,
    output logic [31:0]      daddr,
    output logic [3:0]       dmask,
    output logic [31:0]      dout,
    input  logic [31:0]      din
);

    localparam int unsigned CW         = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int unsigned STARVE_LIM = (STARVE_MAX == 0) ? 0 : STARVE_MAX - 1;

    if (RD_LAT == 0 || RD_LAT > 4 || CNT_W == 0) begin : g_bad_param
        $error("tawas_dbus_arb: RD_LAT must be 1..4 and CNT_W nonzero");
    end

    typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            aux_sel, core_sel, rd_push;
    logic [RD_LAT:0] pv;
    logic [RD_LAT:0] po;

    assign c_rdata = din;

    // Grant, winner select and starvation FSM next state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_gnt     = a_req && (state == STALL || !c_cs);
        aux_sel   = a_gnt;
        core_sel  = c_cs && !a_gnt && (state != STALL);
        rd_push   = (aux_sel && !a_wr) || (core_sel && !c_wr);
        case (state)
            IDLE: begin
                if (a_req && !a_gnt) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT: begin
                if (a_gnt || !a_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (STARVE_MAX != 0 && cnt >= CW'(STARVE_LIM)) begin
                    state_nxt = STALL;
                    cnt_nxt   = '0;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STALL: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered bus drive from the winner; reads and idle cycles drive dout low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcs   <= 1'b0;
            dwr   <= 1'b0;
            daddr <= '0;
            dmask <= '0;
            dout  <= '0;
        end else begin
            dcs   <= aux_sel || core_sel;
            dwr   <= aux_sel ? a_wr : (core_sel && c_wr);
            daddr <= aux_sel ? a_addr : (core_sel ? c_addr : '0);
            dmask <= aux_sel ? a_mask : (core_sel ? c_mask : '0);
            dout  <= (aux_sel && a_wr) ? a_wdata : ((core_sel && c_wr) ? c_wdata : '0);
        end
    end

    // Read ownership pipeline: stage 0 is the bus cycle, stage RD_LAT is the din cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv      <= '0;
            po      <= '0;
            a_rvld  <= 1'b0;
            a_rdata <= '0;
        end else begin
            pv     <= {pv[RD_LAT-1:0], rd_push};
            po     <= {po[RD_LAT-1:0], aux_sel};
            a_rvld <= pv[RD_LAT] && po[RD_LAT];
            if (pv[RD_LAT] && po[RD_LAT]) begin
                a_rdata <= din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_stall <= 1'b0;
            stall_viol <= 1'b0;
        end else begin
            core_stall <= (state_nxt == STALL);
            stall_viol <= stall_viol || (state == STALL && c_cs);
        end
    end

`ifdef TAWAS_DBUS_ARB_STATS_EN
    // Saturating event counters with synchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_aux_gnt  <= '0;
            stat_aux_wait <= '0;
            stat_stall    <= '0;
        end else if (stat_clr) begin
            stat_aux_gnt  <= '0;
            stat_aux_wait <= '0;
            stat_stall    <= '0;
        end else begin
            if (a_gnt && stat_aux_gnt != '1) begin
                stat_aux_gnt <= stat_aux_gnt + CNT_W'(1);
            end
            if (a_req && !a_gnt && stat_aux_wait != '1) begin
                stat_aux_wait <= stat_aux_wait + CNT_W'(1);
            end
            if (state_nxt == STALL && state != STALL && stat_stall != '1) begin
                stat_stall <= stat_stall + CNT_W'(1);
            end
        end
    end
`endif

endmodule
